// File: rtl/uart_arb_pkg.sv
// Shared types, default constants and width helper for the uart_tx_arbiter slice.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      XFER    = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   localparam int DEF_NUM_REQ     = 4;
   localparam int DEF_MAX_BURST   = 16;
   localparam int DEF_TIMEOUT_CYC = 255;

   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr_i, wrapping mod NUM_REQ.
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int   NUM_REQ = DEF_NUM_REQ,
   localparam int  ID_W    = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [ID_W-1:0]    winner_o,
   output logic               any_req_o
);

   logic [ID_W:0] idx;

   // Scan from the farthest offset down so the closest requester to ptr_i wins last.
   always_comb begin
      winner_o  = '0;
      any_req_o = 1'b0;
      idx       = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = {1'b0, ptr_i} + (ID_W+1)'(i);
         if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
         if (req_i[idx[ID_W-1:0]]) begin
            winner_o  = idx[ID_W-1:0];
            any_req_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_packetizer_top among NUM_REQ byte streams.
// Define UART_ARB_TIMEOUT_EN to revoke grants that stall for TIMEOUT_CYC cycles.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int   NUM_REQ     = DEF_NUM_REQ,
   parameter int   MAX_BURST   = DEF_MAX_BURST,
   parameter int   TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   localparam int  ID_W        = clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  logic [8*NUM_REQ-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]   req_last_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   output logic [7:0]           pk_data_in_o,
   output logic                 pk_data_valid_o,
   input  logic                 pk_fifo_full_i,
   input  logic                 pk_tx_busy_i,
   output logic                 grant_active_o,
   output logic [ID_W-1:0]      grant_id_o,
   output logic                 burst_trunc_o,
   output logic                 timeout_evt_o
);

   localparam int              BC_W      = clog2(MAX_BURST + 1);
   localparam logic [BC_W-1:0] BURST_MAX = BC_W'(MAX_BURST);
   localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

   arb_state_t          state_q, state_d;
   logic [ID_W-1:0]     grant_id_q, grant_id_d, rr_ptr_q, rr_ptr_d, winner;
   logic [BC_W-1:0]     burst_cnt_q, burst_cnt_d, burst_inc;
   logic [7:0]          pk_data_q, pk_data_d, cur_data;
   logic                active_q, active_d, pk_vld_q, pk_vld_d, trunc_q, trunc_d;
   logic                any_req, can_accept, xfer, cur_last, burst_hit;
   logic [NUM_REQ-1:0]  req_ready_d;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int              IC_W     = clog2(TIMEOUT_CYC + 1);
   localparam logic [IC_W-1:0] IDLE_MAX = IC_W'(TIMEOUT_CYC);
   logic [IC_W-1:0] idle_cnt_q, idle_cnt_d, idle_inc;
   logic            timeout_q, timeout_d;
   logic            unused_busy;
   assign idle_inc      = idle_cnt_q + IC_W'(1);
   assign timeout_evt_o = timeout_q;
   assign unused_busy   = pk_tx_busy_i;
`else
   logic unused_cfg;
   assign timeout_evt_o = 1'b0;
   assign unused_cfg    = pk_tx_busy_i ^ (TIMEOUT_CYC == 0);
`endif

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i     (req_valid_i),
      .ptr_i     (rr_ptr_q),
      .winner_o  (winner),
      .any_req_o (any_req)
   );

   // Holding off while a byte sits in the output register gives the packetizer a cycle to raise fifo_full.
   assign can_accept = !pk_fifo_full_i && !pk_vld_q;
   assign cur_data   = req_data_i[{grant_id_q, 3'b000} +: 8];
   assign cur_last   = req_last_i[grant_id_q];
   assign xfer       = (state_q == XFER) && req_valid_i[grant_id_q] && can_accept;
   assign burst_inc  = burst_cnt_q + BC_W'(1);
   assign burst_hit  = (burst_inc == BURST_MAX);

   always_comb begin
      state_d     = state_q;
      grant_id_d  = grant_id_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      active_d    = active_q;
      pk_data_d   = pk_data_q;
      pk_vld_d    = 1'b0;
      trunc_d     = 1'b0;
      req_ready_d = '0;
`ifdef UART_ARB_TIMEOUT_EN
      idle_cnt_d  = idle_cnt_q;
      timeout_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d     = XFER;
               grant_id_d  = winner;
               active_d    = 1'b1;
               burst_cnt_d = '0;
`ifdef UART_ARB_TIMEOUT_EN
               idle_cnt_d  = '0;
`endif
            end
         end
         XFER: begin
            req_ready_d[grant_id_q] = can_accept;
            if (xfer) begin
               pk_data_d = cur_data;
               pk_vld_d  = 1'b1;
               if (burst_cnt_q != BURST_MAX) burst_cnt_d = burst_inc;
`ifdef UART_ARB_TIMEOUT_EN
               idle_cnt_d = '0;
`endif
               if (cur_last || burst_hit) begin
                  state_d  = RELEASE;
                  active_d = 1'b0;
                  trunc_d  = !cur_last;
               end
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (idle_inc == IDLE_MAX) begin
               state_d   = RELEASE;
               active_d  = 1'b0;
               timeout_d = 1'b1;
            end else begin
               idle_cnt_d = idle_inc;
            end
`endif
         end
         RELEASE: begin
            rr_ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + ID_W'(1);
            active_d = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_id_q  <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         active_q    <= 1'b0;
         pk_data_q   <= 8'h00;
         pk_vld_q    <= 1'b0;
         trunc_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_id_q  <= grant_id_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         active_q    <= active_d;
         pk_data_q   <= pk_data_d;
         pk_vld_q    <= pk_vld_d;
         trunc_q     <= trunc_d;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         timeout_q  <= timeout_d;
      end
   end
`endif

   assign req_ready_o     = req_ready_d;
   assign pk_data_in_o    = pk_data_q;
   assign pk_data_valid_o = pk_vld_q;
   assign grant_active_o  = active_q;
   assign grant_id_o      = grant_id_q;
   assign burst_trunc_o   = trunc_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_packetizer_top` instance among several byte-stream requesters. It grants the packetizer to one requester per packet and forwards that requester's bytes as single-cycle `data_valid` pulses, with flow control from the packetizer's `fifo_full`. A maximum burst length prevents starvation. The block sits directly in front of `uart_packetizer_top`, on the same clock.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `MAX_BURST`, 16: maximum bytes per grant (1..255).
- `TIMEOUT_CYC`, 255: idle cycles before a stalled grant is revoked. Used only with `UART_ARB_TIMEOUT_EN`.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester byte valid.
- `req_data` in 8*NUM_REQ: per-requester byte. Requester i uses bits [8i+7:8i].
- `req_last` in NUM_REQ: marks the final byte of a packet; qualified by `req_valid`.
- `req_ready` out NUM_REQ: per-requester accept.
- `pk_data_in` out 8: to packetizer `data_in`.
- `pk_data_valid` out 1: to packetizer `data_valid`; one-cycle pulse per byte.
- `pk_fifo_full` in 1: from packetizer `fifo_full`.
- `pk_tx_busy` in 1: from packetizer `tx_busy`; status only.
- `grant_active` out 1: a requester currently owns the packetizer.
- `grant_id` out $clog2(NUM_REQ): current or last owner.
- `burst_trunc` out 1: one-cycle pulse when a grant ends on `MAX_BURST` without `req_last`.
- `timeout_evt` out 1: one-cycle pulse on timeout revoke. Tied to 0 when the feature is compiled out.

## Operation
- The FSM has three states: IDLE, XFER, RELEASE.
- **IDLE → XFER**: taken when any `req_valid` is high. The winner is the first requester with `req_valid` high, searching upward from `rr_ptr` and wrapping modulo NUM_REQ. On entry, latch `grant_id`, set `grant_active`=1, and clear `burst_cnt` and `idle_cnt`.
- **XFER accept rule**: `req_ready[grant_id]` = !`pk_fifo_full` & !`pk_data_valid`. All other `req_ready` bits are 0. A byte transfers when `req_valid` & `req_ready` are both high for the granted requester.
- **XFER per transfer**: register the byte into `pk_data_in`, pulse `pk_data_valid` on the next cycle, and increment `burst_cnt`.
- **XFER → RELEASE**: taken on a transfer with `req_last`, or on a transfer that makes `burst_cnt`==MAX_BURST. In the second case, if `req_last` is 0, `burst_trunc` pulses in the RELEASE cycle.
- **RELEASE → IDLE**: always, after one cycle. In RELEASE, `rr_ptr` ← (`grant_id`+1) mod NUM_REQ and `grant_active` ← 0.
- **Width rules**: `burst_cnt` is $clog2(MAX_BURST+1) bits and saturates at MAX_BURST. `rr_ptr` wraps at NUM_REQ, which need not be a power of two.
- Non-granted requesters see `req_ready`=0 and must hold their data.
- `pk_tx_busy` has no effect on arbitration; the packetizer FIFO absorbs bytes.

## Timing
- Reset values: `req_ready`=0, `pk_data_in`=8'h00, `pk_data_valid`=0, `grant_active`=0, `grant_id`=0, `burst_trunc`=0, `timeout_evt`=0. Internally, state=IDLE, `rr_ptr`=0, and all counters are 0.
- A request in cycle N gives `grant_active`=1 and `req_ready` high at N+1. The first byte accepted at N+1 appears as `pk_data_valid` at N+2.
- Maximum throughput is one byte every 2 cycles. This gap guarantees a registered `fifo_full` is seen before the next accept.
- `pk_fifo_full` high: no accept that cycle. A byte already in the output register is still pulsed, because the packetizer FIFO guarantees one entry of slack after `fifo_full` rises.
- Back-to-back grants: RELEASE costs 1 cycle and IDLE arbitration costs 1 cycle, so the gap between packets is at least 2 cycles.
- Simultaneous `req_last` and the MAX_BURST boundary: treated as a normal end; no `burst_trunc`.
- `req_valid` dropping mid-packet: the grant is held; the block waits for the requester (subject to the timeout, if compiled in).
- Reset mid-packet: the packet is aborted immediately, and any pending `pk_data_valid` is suppressed.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - In XFER, `idle_cnt` increments on every cycle without a transfer and clears on each transfer.
  - When `idle_cnt` reaches TIMEOUT_CYC, the FSM goes to RELEASE and `timeout_evt` pulses for one cycle.
- `UART_ARB_TIMEOUT_EN` undefined:
  - `idle_cnt` is absent and `timeout_evt` is tied to 0.
  - A grant is held indefinitely until `req_last` or MAX_BURST.

## Structure
- Package `uart_arb_pkg`:
  - state enum `arb_state_t` {IDLE, XFER, RELEASE};
  - default constants for MAX_BURST and TIMEOUT_CYC;
  - a function computing `clog2` for widths.
- Sub-module `rr_pick`: combinational round-robin priority selector. Inputs are the request vector and `rr_ptr`; outputs are winner index and `any_req`.

## Test plan
- Single requester (req0) sends A5, 4A, 94, 56 with `req_last` on 56: `pk_data_valid` pulses 4 times in byte order, 2 cycles apart. `grant_id`=0. `grant_active` falls 1 cycle after the 56 transfer.
- All 4 requesters request continuously, 1-byte packets each: grant order is 0,1,2,3,0. No requester is granted twice before the others.
- req1 streams 20 bytes with no `req_last`: exactly 16 bytes are forwarded, then `burst_trunc` pulses once and the grant moves to the next requester.
- `pk_fifo_full` held high for 10 cycles mid-packet: `req_ready` stays 0 throughout, no bytes are lost or duplicated, and transfer resumes 1 cycle after `fifo_full` falls.
- With `UART_ARB_TIMEOUT_EN` and TIMEOUT_CYC=8, req2 stalls after 2 bytes: `timeout_evt` pulses 8 idle cycles later and req3 is then granted. Without the macro, the grant is held for 100+ cycles.
- Reset asserted 1 cycle after an accept: `pk_data_valid` stays 0 and all outputs read their reset values during reset. Re-arbitration after reset starts from requester 0.
